result_nibble_streamer: RTL

Parametrised successor to the LCD nibble path: captures each multiplier result on the rising edge of its done strobe into a DEPTH-entry FIFO. It then streams every entry MSB-first, one nibble per valid/ready handshake, to the display controller. This replaces fixed pointer-indexed nibble selection and the separate slow clock with a single-clock, back-pressured stream. It also adds overflow reporting and flush.

---
 rtl/nibble_pkg.sv | 22 ++
 rtl/result_fifo.sv | 70 +++++++
 rtl/result_nibble_streamer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/nibble_pkg.sv
// Shared types and helpers for the result nibble streamer.
// The ASCII helper is used only when the top is built with NIBBLE_ASCII_EN defined.
package nibble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // 0-9 -> '0'-'9', A-F -> 'A'-'F' (uppercase)
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
        logic [7:0] base;
        base = (n < 4'd10) ? 8'h30 : 8'h37;
        return base + {4'h0, n};
    endfunction

    function automatic int nib_per_word(input int data_w);
        return data_w / 4;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Single-clock FIFO holding captured results until the serializer pops them.
module result_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [DATA_W-1:0]        wdata_i,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/result_nibble_streamer.sv
// Captures multiplier results on the done rising edge and streams them MSB-first, one nibble per handshake.
// Build option: define NIBBLE_ASCII_EN to emit ASCII hex instead of {4'h0, nibble}.
module result_nibble_streamer
    import nibble_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    prod_done,
    input  logic [DATA_W-1:0]       product,
    input  logic                    flush,
    input  logic                    clr_overflow,
    output logic                    nib_valid,
    input  logic                    nib_ready,
    output logic [7:0]              nib_data,
    output logic                    nib_first,
    output logic                    nib_last,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow
);
    localparam int NPW  = nib_per_word(DATA_W);
    localparam int CNTW = $clog2(NPW);
    localparam logic [CNTW-1:0] CNT_TOP = CNTW'(NPW - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              done_dly_q;
    logic              overflow_q, overflow_d;
    logic              nib_valid_q, nib_first_q, nib_last_q;
    logic [7:0]        nib_data_q;

    logic              rise, push, pop, hs;
    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;

    function automatic logic [7:0] nib_fmt(input logic [3:0] n);
`ifdef NIBBLE_ASCII_EN
        return hex_to_ascii(n);
`else
        return {4'h0, n};
`endif
    endfunction

    // Full test is on the registered count, so a same-cycle pop never frees a slot.
    assign rise = prod_done & ~done_dly_q;
    assign push = rise & ~fifo_full;
    assign pop  = (state_q == ST_LOAD);
    assign hs   = (state_q == ST_SHIFT) & nib_ready;

    result_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (product),
        .rdata_o (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow)     overflow_d = 1'b0;
        if (rise & fifo_full) overflow_d = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                shreg_d = fifo_rdata;
                cnt_d   = CNT_TOP;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (hs) begin
                    if (cnt_q != '0) begin
                        shreg_d = {shreg_q[DATA_W-5:0], 4'h0};
                        cnt_d   = cnt_q - 1'b1;
                    end else begin
                        state_d = fifo_empty ? ST_IDLE : ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            cnt_q      <= '0;
            done_dly_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            done_dly_q <= prod_done;
            overflow_q <= overflow_d;
        end
    end

    // Outputs are registered from next-state so they hold steady under back-pressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nib_valid_q <= 1'b0;
            nib_data_q  <= '0;
            nib_first_q <= 1'b0;
            nib_last_q  <= 1'b0;
        end else begin
            nib_valid_q <= (state_d == ST_SHIFT);
            nib_data_q  <= nib_fmt(shreg_d[DATA_W-1 -: 4]);
            nib_first_q <= (state_d == ST_SHIFT) && (cnt_d == CNT_TOP);
            nib_last_q  <= (state_d == ST_SHIFT) && (cnt_d == '0);
        end
    end

    assign nib_valid = nib_valid_q;
    assign nib_data  = nib_data_q;
    assign nib_first = nib_first_q;
    assign nib_last  = nib_last_q;
    assign overflow  = overflow_q;

endmodule
